// File: rtl/rf_rd_arb_pkg.sv
// Shared widths, encodings and defaults for the register-file read arbiter.
// Used by rf_rd_arb; the optional steal counter is enabled with RF_ARB_STAT_EN.
package rf_rd_arb_pkg;

  localparam int RegWidth  = 32;
  localparam int RegAddrW  = 5;

  localparam logic              ReadEnable  = 1'b1;
  localparam logic              ReadDisable = 1'b0;
  localparam logic [RegWidth-1:0] ZeroWord  = '0;

  localparam int StarveMaxDefault = 8;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbWait  = 2'd1,
    ArbSteal = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_rd_arb.sv
// Shares the two regfile read ports between ID and a debug requester, stealing
// port 1 with a one-cycle stall on starvation. Define RF_ARB_STAT_EN for steal_cnt_o.
module rf_rd_arb
  import rf_rd_arb_pkg::*;
#(
  parameter int STARVE_MAX = StarveMaxDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_re1_i,
  input  logic                id_re2_i,
  input  logic [RegAddrW-1:0] id_raddr1_i,
  input  logic [RegAddrW-1:0] id_raddr2_i,
  output logic [RegWidth-1:0] id_rdata1_o,
  output logic [RegWidth-1:0] id_rdata2_o,
  output logic                rf_re1_o,
  output logic                rf_re2_o,
  output logic [RegAddrW-1:0] rf_raddr1_o,
  output logic [RegAddrW-1:0] rf_raddr2_o,
  input  logic [RegWidth-1:0] rf_rdata1_i,
  input  logic [RegWidth-1:0] rf_rdata2_i,
  input  logic                dbg_req_i,
  input  logic [RegAddrW-1:0] dbg_addr_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  output logic [RegWidth-1:0] dbg_rdata_o,
  output logic                stallreq_o
`ifdef RF_ARB_STAT_EN
  ,
  output logic [15:0]         steal_cnt_o
`endif
);

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  arb_state_e          state_q;
  logic [7:0]          starve_cnt_q;
  logic [RegAddrW-1:0] addr_q;
  logic [RegWidth-1:0] rdata_q;
  logic                rvalid_q;

  logic                gnt_port1;
  logic                gnt_port2;
  logic                steal;
  logic [RegWidth-1:0] port_data;

  // Port mux: grants are suppressed during reset so ID always passes through.
  always_comb begin
    gnt_port1   = 1'b0;
    gnt_port2   = 1'b0;
    steal       = 1'b0;
    rf_re1_o    = id_re1_i;
    rf_raddr1_o = id_raddr1_i;
    rf_re2_o    = id_re2_i;
    rf_raddr2_o = id_raddr2_i;
    id_rdata1_o = rf_rdata1_i;
    id_rdata2_o = rf_rdata2_i;
    if (!rst) begin
      case (state_q)
        ArbWait: begin
          if (!id_re2_i)      gnt_port2 = 1'b1;
          else if (!id_re1_i) gnt_port1 = 1'b1;
        end
        ArbSteal: begin
          gnt_port1 = 1'b1;
          steal     = 1'b1;
        end
        default: ;
      endcase
    end
    if (gnt_port1) begin
      rf_re1_o    = ReadEnable;
      rf_raddr1_o = addr_q;
    end
    if (gnt_port2) begin
      rf_re2_o    = ReadEnable;
      rf_raddr2_o = addr_q;
    end
    // ID's port-1 result is thrown away while it is stalled.
    if (steal) id_rdata1_o = ZeroWord;
  end

  assign port_data    = gnt_port2 ? rf_rdata2_i : rf_rdata1_i;
  assign dbg_gnt_o    = gnt_port1 | gnt_port2;
  assign stallreq_o   = steal;
  assign dbg_rvalid_o = rvalid_q;
  assign dbg_rdata_o  = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ArbIdle;
      starve_cnt_q <= 8'd0;
      addr_q       <= '0;
      rdata_q      <= ZeroWord;
      rvalid_q     <= 1'b0;
    end else begin
      rvalid_q <= dbg_gnt_o;
      if (dbg_gnt_o) rdata_q <= port_data;
      case (state_q)
        ArbIdle: begin
          if (dbg_req_i) begin
            addr_q       <= dbg_addr_i;
            starve_cnt_q <= 8'd0;
            state_q      <= ArbWait;
          end
        end
        ArbWait: begin
          // A free port always wins over a steal, even at the starvation limit.
          if (dbg_gnt_o)                       state_q <= ArbIdle;
          else if (starve_cnt_q == StarveMax)  state_q <= ArbSteal;
          else                                 starve_cnt_q <= starve_cnt_q + 8'd1;
        end
        ArbSteal: state_q <= ArbIdle;
        default:  state_q <= ArbIdle;
      endcase
    end
  end

`ifdef RF_ARB_STAT_EN
  logic [15:0] steal_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                    steal_cnt_q <= 16'd0;
    else if (steal && steal_cnt_q != 16'hFFFF)  steal_cnt_q <= steal_cnt_q + 16'd1;
  end

  assign steal_cnt_o = steal_cnt_q;
`endif

endmodule

// File: doc/rf_rd_arb.md
# rf_rd_arb

Arbitrates the two register-file read ports between the ID stage and the debug unit. ID reads always pass through combinationally. Debug reads use a port that ID leaves idle in that cycle. If debug waits too long, the block requests a one-cycle pipeline stall and takes a port. It sits between `id`/`regfile` and reports its stall request to the pipeline controller.

## Interface
- `STARVE_MAX`, default 8: number of WAIT cycles without a free port before a steal is forced; range 0–255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `id_re1_i` / `id_re2_i` in 1: ID read enables.
- `id_raddr1_i` / `id_raddr2_i` in `RegAddrBus`: ID read addresses.
- `id_rdata1_o` / `id_rdata2_o` out `RegBus`: read data returned to ID.
- `rf_re1_o` / `rf_re2_o` out 1: regfile read enables.
- `rf_raddr1_o` / `rf_raddr2_o` out `RegAddrBus`: regfile read addresses.
- `rf_rdata1_i` / `rf_rdata2_i` in `RegBus`: regfile read data, combinational.
- `dbg_req_i` in 1: debug read request, level.
- `dbg_addr_i` in `RegAddrBus`: debug register address.
- `dbg_gnt_o` out 1: one-cycle pulse in the cycle the debug read is performed.
- `dbg_rvalid_o` out 1: one-cycle pulse; `dbg_rdata_o` is valid.
- `dbg_rdata_o` out `RegBus`: debug read data.
- `stallreq_o` out 1: stall request to the pipeline controller.
- `steal_cnt_o` out 16: number of steals; present only with `RF_ARB_STAT_EN`.

## Operation
- FSM states: IDLE, WAIT, STEAL.
- IDLE
  - When `dbg_req_i`=1: latch `dbg_addr_i` into `addr_q`, clear `starve_cnt`, go to WAIT.
  - No port is used for debug in this cycle.
- WAIT
  - Port 2 is free if `id_re2_i`=0; port 1 is free if `id_re1_i`=0. Port 2 is preferred.
  - If a port is free: drive it with `ReadEnable` and `addr_q`, assert `dbg_gnt_o`, register the port data into `dbg_rdata_o`, go to IDLE.
  - If no port is free and `starve_cnt`==`STARVE_MAX`: go to STEAL.
  - Otherwise: `starve_cnt`+1, stay in WAIT.
  - A free port in the cycle the count reaches `STARVE_MAX` is used normally. No steal occurs.
- STEAL
  - `stallreq_o`=1.
  - Port 1 is forced to `addr_q` and ID's port-1 request is ignored.
  - ID's data this cycle is discarded: the controller freezes the ID/EX register and ID re-decodes next cycle.
  - Assert `dbg_gnt_o`, capture `rf_rdata1_i`, go to IDLE.
- Any port not granted to debug carries ID's enable, address and data unmodified. Outside STEAL, `id_rdata*_o` = `rf_rdata*_i`.
- `dbg_rvalid_o` is registered and pulses the cycle after `dbg_gnt_o`.
- Requester protocol:
  - `dbg_req_i` is held until `dbg_gnt_o`.
  - `dbg_addr_i` is sampled only in IDLE.
  - If `dbg_req_i` is still high in the cycle after the grant (back in IDLE), that is a new request.
- Reading register 0 returns the regfile's value, i.e. zero. No special-casing here.
- `starve_cnt` is 8 bits and never exceeds `STARVE_MAX`.

## Timing
- Reset values: state=IDLE, `starve_cnt`=0, `addr_q`=0, `dbg_rdata_o`=`ZeroWord`, `dbg_rvalid_o`=0, `steal_cnt_o`=0.
- While `rst`=1: `dbg_gnt_o`=0, `stallreq_o`=0, and ports pass ID through.
- Minimum latency: request sampled in cycle 0, grant in cycle 1, `dbg_rvalid_o` in cycle 2.
- Maximum latency: grant in cycle `STARVE_MAX`+2, `dbg_rvalid_o` in cycle `STARVE_MAX`+3.
- With `STARVE_MAX`=0: WAIT lasts one cycle; the steal follows immediately if no port is free.
- `stallreq_o` is combinational from state and is high for exactly one cycle per steal. Steals are never back-to-back: at least one IDLE cycle lies between them.
- Reset mid-operation: the pending request is dropped and no `dbg_rvalid_o` is produced. If the grant was in the reset cycle, the following rvalid is also suppressed.

## Configuration
- `RF_ARB_STAT_EN` defined:
  - Adds `steal_cnt_o`, a 16-bit counter incremented on each STEAL cycle.
  - Saturates at 16'hFFFF; cleared by `rst`.
- Not defined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- `defines.v` gains:
  - State encodings `ArbIdle`, `ArbWait`, `ArbSteal` (2 bits) and `ArbStateBus`.
  - Default `StarveMaxDefault` = 8.
- Existing `RegBus`, `RegAddrBus`, `ReadEnable`, `ReadDisable` and `ZeroWord` are reused.
- No sub-module: FSM, counter and port mux live in one module.

## Test plan
- Idle ID (`id_re1_i`=`id_re2_i`=0), debug req for addr 5 where reg5=32'h1234 -> grant on port 2 in cycle 1; `dbg_rvalid_o` with 32'h1234 in cycle 2; `stallreq_o` stays 0.
- `id_re2_i`=1, `id_re1_i`=0 -> debug uses port 1; ID port 2 data unaffected.
- Both ID ports busy continuously, `STARVE_MAX`=3 -> `stallreq_o`=1 exactly in cycle 5; port 1 address = `addr_q`; rvalid in cycle 6.
- Both ports busy, then port 2 freed in the cycle `starve_cnt`==`STARVE_MAX` -> grant on port 2, no stall.
- `rst` asserted in a WAIT cycle -> no grant, no rvalid; next request starts from IDLE.
- `RF_ARB_STAT_EN` with three forced steals -> `steal_cnt_o`=3; after `rst`, 0.
